pipo_share_arbiter: RTL

Shares one WIDTH-bit parallel-in/parallel-out register among NREQ requesters. A round-robin arbiter grants one requester at a time. The block loads that requester's parallel data into the shared register and returns a one-cycle acknowledge. It sits between multiple producer blocks and the shared PIPO storage, and it owns that register's load/clear sequencing.

---
 rtl/pipo_share_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipo_share_arbiter.sv
// Round-robin shared PIPO register: grants one requester, loads its slice,
// pulses ack. Ports: clk, rst(async low), req, din, clr, gnt, ack, q, owner, valid, busy.
module pipo_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [2:0]            owner,
  output logic                  valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [3:0] NR = 4'(NREQ);

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       sel;
  logic [2:0]       pick;
  logic             hit;
  logic [3:0]       idx;
  logic [WIDTH-1:0] slice;
  logic [2:0]       nxt;

  // first set request scanning upward from ptr, wrapping
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= NR) idx = idx - NR;
      if (!hit && |(req & (ONE << idx))) begin
        hit  = 1'b1;
        pick = idx[2:0];
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == 3'(i)) slice = din[i*WIDTH +: WIDTH];
    end
  end

  assign nxt = (sel == 3'(NREQ-1)) ? 3'd0 : sel + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            q     <= '0;
            valid <= 1'b0;
          end else if (hit) begin
            sel   <= pick;
            gnt   <= ONE << pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          q     <= slice;
          owner <= sel;
          valid <= 1'b1;
          gnt   <= '0;
          ack   <= ONE << sel;
          ptr   <= nxt;
          state <= DONE;
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
